// File: rtl/led_pattern_ctrl_if.sv
// Command channel into the LED pattern sequencer: mode + speed with valid/ready.
// Latency: none, this is wiring only.
// Backpressure: the producer holds cmd_valid and its payload until cmd_ready is seen high at a clock edge.
//
// Signals:
//   cmd_valid  producer -> sequencer  command present
//   cmd_ready  sequencer -> producer  command can be accepted this edge
//   cmd_mode   producer -> sequencer  0=OFF 1=BLINK 2=CHASE 3=BOUNCE
//   cmd_speed  producer -> sequencer  step period = cmd_speed+1 prescaler ticks
interface led_pattern_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_speed;

  modport master (
    output cmd_valid,
    output cmd_mode,
    output cmd_speed,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_mode,
    input  cmd_speed,
    output cmd_ready
  );
endinterface

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer (OFF/BLINK/CHASE/BOUNCE) timed by a prescaler and a speed divider.
// Latency: a command accepted in IDLE applies one edge later; in RUN it applies on the next step edge.
// Backpressure: one command slot; cmd_ready is low while a command is pending, so the host must hold cmd_valid.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   cmd         command channel (slave side of led_pattern_ctrl_if)
//   leds        registered LED drive, 1 = on
//   cycle_done  one-cycle pulse on the step edge that completes a pattern period
//   busy        high whenever the FSM is not in IDLE
module led_pattern_ctrl #(
  parameter int N_LED   = 8,
  parameter int CLK_DIV = 1000
) (
  input  logic               clk,
  input  logic               rst,
  led_pattern_ctrl_if.slave  cmd,
  output logic [N_LED-1:0]   leds,
  output logic               cycle_done,
  output logic               busy
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]    PMAX = PW'(CLK_DIV - 1);
  localparam logic [N_LED-1:0] ONE  = N_LED'(1);

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_CHASE  = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_LED-1:0] leds_q, leds_d;
  logic             done_q, done_d;
  logic             dir_q, dir_d;      // 0 = moving toward MSB, 1 = toward LSB
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       speed_q, speed_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [3:0]       scnt_q, scnt_d;
  logic             pend_q, pend_d;
  logic [1:0]       pmode_q, pmode_d;
  logic [3:0]       pspeed_q, pspeed_d;

  logic             accept;
  logic             tick;
  logic             step;
  logic             apply;

  logic [N_LED-1:0] pat_nxt;
  logic             pat_done;
  logic             pat_dir;

  assign accept = cmd.cmd_valid && !pend_q;
  assign tick   = (state_q != ST_IDLE) && (presc_q == PMAX);
  assign step   = tick && (scnt_q == speed_q);
  // A pending command lands immediately from IDLE, otherwise it replaces a step.
  assign apply  = pend_q && ((state_q == ST_IDLE) || ((state_q == ST_PEND) && step));

  // Next pattern value for a normal step of the current mode.
  always_comb begin
    pat_nxt  = leds_q;
    pat_done = 1'b0;
    pat_dir  = dir_q;
    case (mode_q)
      MODE_BLINK: begin
        pat_nxt  = ~leds_q;
        pat_done = (~leds_q == '1);
      end
      MODE_CHASE: begin
        // Rotate left; for a single LED this degenerates to holding bit0.
        pat_nxt  = (leds_q << 1) | (leds_q >> (N_LED - 1));
        pat_done = (pat_nxt == ONE);
      end
      MODE_BOUNCE: begin
        if (N_LED == 1) begin
          pat_nxt  = ONE;
          pat_done = 1'b1;
          pat_dir  = 1'b0;
        end else if (!dir_q) begin
          pat_nxt = leds_q << 1;
          pat_dir = pat_nxt[N_LED-1];
        end else begin
          pat_nxt  = leds_q >> 1;
          pat_dir  = ~pat_nxt[0];
          pat_done = pat_nxt[0];
        end
      end
      default: begin
        pat_nxt = '0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    leds_d   = leds_q;
    done_d   = 1'b0;
    dir_d    = dir_q;
    mode_d   = mode_q;
    speed_d  = speed_q;
    presc_d  = presc_q;
    scnt_d   = scnt_q;
    pend_d   = pend_q;
    pmode_d  = pmode_q;
    pspeed_d = pspeed_q;

    if (accept) begin
      pend_d   = 1'b1;
      pmode_d  = cmd.cmd_mode;
      pspeed_d = cmd.cmd_speed;
    end

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        scnt_d  = '0;
        leds_d  = '0;
      end
      default: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          scnt_d = (scnt_q == speed_q) ? 4'd0 : scnt_q + 4'd1;
        end
        if (step && (state_q == ST_RUN || !pend_q)) begin
          leds_d = pat_nxt;
          dir_d  = pat_dir;
          done_d = pat_done;
        end
        if (accept) begin
          state_d = ST_PEND;
        end
      end
    endcase

    if (apply) begin
      pend_d  = 1'b0;
      mode_d  = pmode_q;
      speed_d = pspeed_q;
      presc_d = '0;
      scnt_d  = '0;
      dir_d   = 1'b0;
      done_d  = 1'b0;
      if (pmode_q == MODE_OFF) begin
        state_d = ST_IDLE;
        leds_d  = '0;
      end else begin
        state_d = ST_RUN;
        leds_d  = (pmode_q == MODE_BLINK) ? '1 : ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      leds_q   <= '0;
      done_q   <= 1'b0;
      dir_q    <= 1'b0;
      mode_q   <= MODE_OFF;
      speed_q  <= 4'd0;
      presc_q  <= '0;
      scnt_q   <= 4'd0;
      pend_q   <= 1'b0;
      pmode_q  <= MODE_OFF;
      pspeed_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      leds_q   <= leds_d;
      done_q   <= done_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      speed_q  <= speed_d;
      presc_q  <= presc_d;
      scnt_q   <= scnt_d;
      pend_q   <= pend_d;
      pmode_q  <= pmode_d;
      pspeed_q <= pspeed_d;
    end
  end

  assign cmd.cmd_ready = ~pend_q;
  assign leds          = leds_q;
  assign cycle_done    = done_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl: N_LED=4/CLK_DIV=4 main instance,
// plus N_LED=8/CLK_DIV=1000 and N_LED=1/CLK_DIV=2 corner instances.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_led_pattern_ctrl;

  logic clk;
  logic rst;

  logic [3:0] leds4;
  logic       done4;
  logic       busy4;
  logic [7:0] leds8;
  logic       done8;
  logic       busy8;
  logic [0:0] leds1;
  logic       done1;
  logic       busy1;

  int n_pass  = 0;
  int n_total = 0;
  int extra;

  led_pattern_ctrl_if c4 ();
  led_pattern_ctrl_if c8 ();
  led_pattern_ctrl_if c1 ();

  led_pattern_ctrl #(.N_LED(4), .CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .cmd(c4), .leds(leds4), .cycle_done(done4), .busy(busy4)
  );

  led_pattern_ctrl #(.N_LED(8), .CLK_DIV(1000)) dut8 (
    .clk(clk), .rst(rst), .cmd(c8), .leds(leds8), .cycle_done(done8), .busy(busy8)
  );

  led_pattern_ctrl #(.N_LED(1), .CLK_DIV(2)) dut1 (
    .clk(clk), .rst(rst), .cmd(c1), .leds(leds1), .cycle_done(done1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present a command on the main instance, wait (bounded) for ready, and
  // return on the falling edge right after the accepting rising edge.
  task automatic send(input logic [1:0] m, input logic [3:0] s);
    int n;
    n = 0;
    c4.cmd_valid = 1'b1;
    c4.cmd_mode  = m;
    c4.cmd_speed = s;
    while (c4.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_seen", {31'd0, c4.cmd_ready}, 32'd1);
    @(negedge clk);
    c4.cmd_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] chase_exp [4];
    logic [3:0] bounce_exp [6];
    logic [3:0] prev;
    chase_exp  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bounce_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

    rst = 1'b0;
    c4.cmd_valid = 1'b0; c4.cmd_mode = 2'd0; c4.cmd_speed = 4'd0;
    c8.cmd_valid = 1'b0; c8.cmd_mode = 2'd0; c8.cmd_speed = 4'd0;
    c1.cmd_valid = 1'b0; c1.cmd_mode = 2'd0; c1.cmd_speed = 4'd0;

    // Reset held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_leds", {28'd0, leds4}, 32'd0);
      chk("rst_done", {31'd0, done4}, 32'd0);
      chk("rst_busy", {31'd0, busy4}, 32'd0);
      chk("rst_ready", {31'd0, c4.cmd_ready}, 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_leds", {28'd0, leds4}, 32'd0);
    chk("post_rst_ready", {31'd0, c4.cmd_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy4}, 32'd0);

    // CHASE speed=0 from IDLE
    send(2'd2, 4'd0);
    chk("chase_pending_ready", {31'd0, c4.cmd_ready}, 32'd0);
    @(negedge clk);
    chk("chase_init", {28'd0, leds4}, 32'h1);
    chk("chase_init_done", {31'd0, done4}, 32'd0);
    chk("chase_busy", {31'd0, busy4}, 32'd1);
    chk("chase_ready_back", {31'd0, c4.cmd_ready}, 32'd1);
    prev = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      extra = 0;
      repeat (3) begin
        @(negedge clk);
        if (done4) extra++;
      end
      chk("chase_hold", {28'd0, leds4}, {28'd0, prev});
      chk("chase_no_early_done", extra, 0);
      @(negedge clk);
      chk("chase_step", {28'd0, leds4}, {28'd0, chase_exp[i]});
      chk("chase_done", {31'd0, done4}, (i == 3) ? 32'd1 : 32'd0);
      prev = chase_exp[i];
    end

    // Mid-run change to BLINK, sent shortly after a step
    @(negedge clk);
    send(2'd1, 4'd0);
    chk("mid_ready_low", {31'd0, c4.cmd_ready}, 32'd0);
    chk("mid_old_pattern", {28'd0, leds4}, 32'h1);
    @(negedge clk);
    chk("mid_ready_still_low", {31'd0, c4.cmd_ready}, 32'd0);
    @(negedge clk);
    chk("mid_blink_init", {28'd0, leds4}, 32'hF);
    chk("mid_ready_high", {31'd0, c4.cmd_ready}, 32'd1);
    chk("mid_init_no_done", {31'd0, done4}, 32'd0);
    repeat (3) @(negedge clk);
    chk("blink_hold", {28'd0, leds4}, 32'hF);
    @(negedge clk);
    chk("blink_off_phase", {28'd0, leds4}, 32'h0);
    chk("blink_off_no_done", {31'd0, done4}, 32'd0);
    repeat (4) @(negedge clk);
    chk("blink_on_phase", {28'd0, leds4}, 32'hF);
    chk("blink_done", {31'd0, done4}, 32'd1);

    // Backpressure: second command (OFF) held while the first is pending
    c4.cmd_valid = 1'b1; c4.cmd_mode = 2'd2; c4.cmd_speed = 4'd0;
    @(negedge clk);
    chk("bp_first_taken", {31'd0, c4.cmd_ready}, 32'd0);
    chk("blink_done_one_cycle", {31'd0, done4}, 32'd0);
    c4.cmd_mode = 2'd0;
    @(negedge clk);
    chk("bp_ready_low_a", {31'd0, c4.cmd_ready}, 32'd0);
    @(negedge clk);
    chk("bp_ready_low_b", {31'd0, c4.cmd_ready}, 32'd0);
    chk("bp_old_blink", {28'd0, leds4}, 32'hF);
    @(negedge clk);
    chk("bp_first_applied", {28'd0, leds4}, 32'h1);
    chk("bp_ready_high", {31'd0, c4.cmd_ready}, 32'd1);
    @(negedge clk);
    chk("bp_second_taken", {31'd0, c4.cmd_ready}, 32'd0);
    c4.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("off_pending_leds", {28'd0, leds4}, 32'h1);
    chk("off_pending_busy", {31'd0, busy4}, 32'd1);
    @(negedge clk);
    chk("off_leds", {28'd0, leds4}, 32'h0);
    chk("off_busy", {31'd0, busy4}, 32'd0);
    chk("off_ready", {31'd0, c4.cmd_ready}, 32'd1);
    chk("off_no_done", {31'd0, done4}, 32'd0);

    // BOUNCE speed=1
    send(2'd3, 4'd1);
    @(negedge clk);
    chk("bounce_init", {28'd0, leds4}, 32'h1);
    prev = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      extra = 0;
      repeat (7) begin
        @(negedge clk);
        if (done4) extra++;
      end
      chk("bounce_hold", {28'd0, leds4}, {28'd0, prev});
      chk("bounce_no_early_done", extra, 0);
      @(negedge clk);
      chk("bounce_step", {28'd0, leds4}, {28'd0, bounce_exp[i]});
      chk("bounce_done", {31'd0, done4}, (i == 5) ? 32'd1 : 32'd0);
      prev = bounce_exp[i];
    end

    // Async reset mid-BLINK with a command pending
    send(2'd1, 4'd0);
    repeat (7) @(negedge clk);
    chk("ar_blink", {28'd0, leds4}, 32'hF);
    send(2'd2, 4'd0);
    chk("ar_pending", {31'd0, c4.cmd_ready}, 32'd0);
    chk("ar_pre_leds", {28'd0, leds4}, 32'hF);
    #2 rst = 1'b0;
    #1;
    chk("ar_leds_now", {28'd0, leds4}, 32'h0);
    chk("ar_ready_now", {31'd0, c4.cmd_ready}, 32'd1);
    chk("ar_busy_now", {31'd0, busy4}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("ar_discarded_leds", {28'd0, leds4}, 32'h0);
    chk("ar_discarded_busy", {31'd0, busy4}, 32'd0);

    // N_LED=1 BOUNCE: holds bit0 and completes a period every step
    c1.cmd_valid = 1'b1; c1.cmd_mode = 2'd3; c1.cmd_speed = 4'd0;
    @(negedge clk);
    c1.cmd_valid = 1'b0;
    @(negedge clk);
    chk("n1_init", {31'd0, leds1}, 32'd1);
    chk("n1_busy", {31'd0, busy1}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("n1_between", {31'd0, done1}, 32'd0);
      @(negedge clk);
      chk("n1_leds", {31'd0, leds1}, 32'd1);
      chk("n1_done", {31'd0, done1}, 32'd1);
    end

    // N_LED=8, CLK_DIV=1000: CHASE speed=0 steps every 1000 cycles
    c8.cmd_valid = 1'b1; c8.cmd_mode = 2'd2; c8.cmd_speed = 4'd0;
    @(negedge clk);
    c8.cmd_valid = 1'b0;
    @(negedge clk);
    chk("n8_init", {24'd0, leds8}, 32'h01);
    chk("n8_busy", {31'd0, busy8}, 32'd1);
    repeat (999) @(negedge clk);
    chk("n8_hold", {24'd0, leds8}, 32'h01);
    @(negedge clk);
    chk("n8_step1", {24'd0, leds8}, 32'h02);
    chk("n8_no_done", {31'd0, done8}, 32'd0);
    repeat (1000) @(negedge clk);
    chk("n8_step2", {24'd0, leds8}, 32'h04);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Sequencer that drives a bank of N_LED LEDs with one of four patterns: OFF, BLINK, CHASE or BOUNCE.
- Pattern steps are timed by an internal prescaler plus a programmable speed divider.
- A valid/ready command port lets a host or config block change the mode and speed; changes take effect only on step boundaries.
- Sits between top-level control and the board LED pins, replacing the free-running single-LED blinker.

Parameters:
- N_LED, 8: number of LED outputs; legal range 1..32.
- CLK_DIV, 1000: clk cycles per prescaler tick; legal range ≥2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_mode  input  2  0=OFF, 1=BLINK, 2=CHASE, 3=BOUNCE.
- cmd_speed  input  4  step period = (cmd_speed+1) prescaler ticks.
- leds  output  N_LED  registered LED drive, 1=on.
- cycle_done  output  1  one-cycle pulse when a pattern period completes.
- busy  output  1  1 when the FSM is in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous): leds=0, cycle_done=0, busy=0, cmd_ready=1, FSM=IDLE, prescaler=0, step counter=0, no command pending.
- Handshake:
  - A command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_mode and cmd_speed are latched.
  - cmd_ready=0 while a command is pending.
  - cmd_valid while cmd_ready=0 is ignored; the host must hold it.
- FSM states: IDLE, RUN, PEND.
- IDLE:
  - Prescaler held at 0; leds=0.
  - An accepted command applies on the next edge: mode loaded, pattern initialised, prescaler cleared, state→RUN.
  - An accepted mode=OFF stays in IDLE.
- RUN:
  - Prescaler counts 0..CLK_DIV-1 and wraps; tick fires when prescaler=CLK_DIV-1.
  - Step counter counts ticks 0..speed; a step fires on the tick where step counter=speed, then the counter clears.
  - leds update on the clock edge of the step cycle.
  - An accepted command → PEND.
- PEND: keeps stepping the old pattern. At the next step edge the pending command is applied instead of a normal step:
  - Pattern re-initialised, speed replaced, prescaler and step counters cleared.
  - State→RUN, or →IDLE with leds=0 if the mode is OFF.
  - cmd_ready returns to 1 on that same edge.
- Pattern initial values and step rules:
  - BLINK: init all-ones; each step inverts all bits.
  - CHASE: init bit0=1, others 0; each step rotates left, bit N_LED-1 wraps to bit0.
  - BOUNCE: init bit0=1 with direction=up; each step shifts toward the MSB while up, reversing at bit N_LED-1; shifts toward the LSB while down, reversing at bit0. Period is 2·N_LED-2 steps.
- cycle_done pulses for one cycle, coincident with the step edge that:
  - BLINK: returns leds to all-ones.
  - CHASE: wraps to bit0.
  - BOUNCE: arrives at bit0.
  - Never pulses on an init edge or in OFF/IDLE.
- N_LED=1:
  - CHASE and BOUNCE hold bit0=1 and pulse cycle_done on every step.
  - BOUNCE direction stays up.
- A re-command of the same mode is legal; it restarts the pattern from init at the next step.
- Widths: prescaler is clog2(CLK_DIV) bits; step counter is 4 bits with no overflow possible.
- Reset asserted mid-operation clears everything immediately; a pending command is discarded.

Test Plan (CLK_DIV=4, N_LED=4 unless stated):
- Reset: hold rst=0 for 10 cycles, release → leds=0000, cmd_ready=1, busy=0, cycle_done=0 throughout.
- CHASE speed=0 from IDLE:
  - 1 cycle after accept: leds=0001.
  - Then every 4 cycles: 0010, 0100, 1000, 0001.
  - cycle_done pulses exactly on the 1000→0001 edge.
- BOUNCE speed=1: leds change every 8 cycles through 0001, 0010, 0100, 1000, 0100, 0010, 0001; cycle_done pulses only when 0001 is reached.
- Mid-run change: CHASE speed=0, send BLINK two cycles after a step →
  - cmd_ready=0 until the next step edge.
  - At that edge leds=1111 (not the next chase value) and cmd_ready=1.
  - Four cycles later leds=0000.
- OFF command and backpressure: while in PEND, cmd_valid is held with a second command → it is not accepted until cmd_ready=1. Sending OFF → leds=0000 and busy=0 at the applying step edge.
- Async reset mid-BLINK with a command pending → leds=0000 and cmd_ready=1 immediately, without waiting for a clk edge. With CLK_DIV=1000 and N_LED=8, CHASE speed=0 steps every 1000 cycles.
